apb_bridge_top: RTL and testbench
=================================

# apb_bridge_top

Self-contained APB subsystem: one APB master FSM converting a simple transfer request into APB SETUP/ACCESS phases, driving two internal 8-bit memory-mapped slaves over a shared bus. Sits under the testbench as the full DUT. It exposes only the request side and returns read data and an error flag. The internal APB bus (PSEL1/PSEL2, PENABLE, PWRITE, PADDR, PWDATA, PREADY, PRDATA) is not a port.

## Interface
- No parameters.
- PCLK  in  1  clock; all state changes on rising edge.
- PRESETn  in  1  reset, asynchronous and active-high. Asserted when 1, despite the suffix.
- transfer  in  1  request a transaction; sampled each PCLK edge.
- READ_WRITE  in  1  1 = read, 0 = write.
- apb_write_paddr  in  9  write address; bit 8 selects slave (0 = slave1, 1 = slave2), bits 7:0 = byte offset.
- apb_write_data  in  8  write data.
- apb_read_paddr  in  9  read address, same decoding.
- apb_read_data_out  out  8  last completed read data.
- PSLVERR  out  1  error flag for the completing transfer.

## Operation
- Master FSM states: IDLE, SETUP, ACCESS.
  - IDLE: stays while transfer=0. Goes to SETUP when transfer=1 and latches READ_WRITE and the relevant address/data.
  - SETUP: PSELx=1, PENABLE=0. Always goes to ACCESS.
  - ACCESS: PSELx=1, PENABLE=1. Waits while PREADY=0.
  - On PREADY=1 the transfer completes. The FSM then goes to SETUP if transfer=1 (relatching new request) or to IDLE.
- Address used: apb_read_paddr for reads, apb_write_paddr for writes.
- Slave1 implements 256 bytes (offsets 0x00-0xFF).
- Slave2 implements 128 bytes (offsets 0x00-0x7F).
  - Slave2 offsets 0x80-0xFF are unmapped and return PSLVERR=1 on completion.
  - Unmapped writes are dropped. Unmapped reads leave apb_read_data_out unchanged.
- Write completion: memory[offset] <= write data.
- Read completion: apb_read_data_out <= memory[offset].
- PSLVERR is registered. It is 1 only for the cycle after an erroring transfer completes, and 0 otherwise.
- Request inputs are ignored outside IDLE→SETUP and ACCESS-completion transitions.

## Timing
- Reset state:
  - FSM = IDLE.
  - apb_read_data_out = 0x00.
  - PSLVERR = 0.
  - All memory bytes = 0x00.
- Reset mid-transfer aborts immediately; no memory write occurs.
- Zero-wait latency: request sampled at edge N, SETUP during N..N+1, ACCESS during N+1..N+2. Completes at edge N+2. Read data and PSLVERR are valid after edge N+2.
- Back-to-back: transfer held high gives one transaction every 2 cycles (3 with wait state).
- Read-after-write to the same address returns the new data.

## Configuration
- WAIT_STATE_EN defined: each slave drives PREADY=0 on the first ACCESS cycle and 1 on the second. Every transfer takes 3 cycles.
- WAIT_STATE_EN undefined: PREADY is tied 1. Every transfer takes 2 cycles.
- Functional results are identical either way.

## Test plan
- Reset (PRESETn=1 for 2 cycles, transfer=0) → apb_read_data_out=0x00, PSLVERR=0, FSM IDLE.
- Write 0xA5 to 0x010, then read 0x010 → apb_read_data_out=0xA5 two cycles after the read request, PSLVERR=0.
- Write 0x3C to 0x105 (slave2), read 0x105 and 0x005 → 0x3C, then 0x00. Confirms slave separation.
- Read 0x1F0 (unmapped) → PSLVERR=1 for one cycle, apb_read_data_out unchanged. Write 0x77 to 0x1F0 → PSLVERR=1, no memory change.
- transfer held high over 4 alternating writes and reads → completes one every 2 cycles (3 with WAIT_STATE_EN), all data correct.
- PRESETn asserted during ACCESS of write 0x55 to 0x020 → afterwards read 0x020 returns 0x00.

Source files
------------

// File: rtl/apb_bridge_top.sv
// apb_bridge_top: APB master FSM driving two internal byte-wide APB slaves.
// Slave1 maps 256 bytes (address bit 8 = 0), slave2 maps 128 bytes (bit 8 = 1).
// Slave2 offsets 0x80-0xFF are unmapped and complete with PSLVERR.
// Optional macro WAIT_STATE_EN: slaves insert one wait state per ACCESS phase.
module apb_bridge_top (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       transfer,
  input  logic       READ_WRITE,
  input  logic [8:0] apb_write_paddr,
  input  logic [7:0] apb_write_data,
  input  logic [8:0] apb_read_paddr,
  output logic [7:0] apb_read_data_out,
  output logic       PSLVERR
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_psel1;
  logic        r_psel2;
  logic        r_penable;
  logic        r_pwrite;
  logic [7:0]  r_paddr;
  logic [7:0]  r_pwdata;
  logic [7:0]  r_rdata;
  logic        r_pslverr;
  logic [7:0]  r_mem1 [0:255];
  logic [7:0]  r_mem2 [0:127];

  logic [8:0]  w_req_addr;
  logic        w_pready1;
  logic        w_pready2;
  logic        w_pready;
  logic        w_complete;
  logic [7:0]  w_prdata;
  logic        w_slverr;

  // The address of a new request depends on its direction.
  assign w_req_addr = READ_WRITE ? apb_read_paddr : apb_write_paddr;

  // Master FSM: latches the request and drives PSELx/PENABLE as registers.
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      r_state   <= ST_IDLE;
      r_psel1   <= 1'b0;
      r_psel2   <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= 8'h00;
      r_pwdata  <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (transfer) begin
            r_state  <= ST_SETUP;
            r_psel1  <= ~w_req_addr[8];
            r_psel2  <= w_req_addr[8];
            r_pwrite <= ~READ_WRITE;
            r_paddr  <= w_req_addr[7:0];
            r_pwdata <= apb_write_data;
          end
        end
        ST_SETUP: begin
          r_state   <= ST_ACCESS;
          r_penable <= 1'b1;
        end
        ST_ACCESS: begin
          if (w_pready) begin
            r_penable <= 1'b0;
            if (transfer) begin
              r_state  <= ST_SETUP;
              r_psel1  <= ~w_req_addr[8];
              r_psel2  <= w_req_addr[8];
              r_pwrite <= ~READ_WRITE;
              r_paddr  <= w_req_addr[7:0];
              r_pwdata <= apb_write_data;
            end else begin
              r_state <= ST_IDLE;
              r_psel1 <= 1'b0;
              r_psel2 <= 1'b0;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_psel1   <= 1'b0;
          r_psel2   <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

`ifdef WAIT_STATE_EN
  logic r_ws1;
  logic r_ws2;

  // Each slave holds PREADY low on its first ACCESS cycle, high on the second.
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      r_ws1 <= 1'b0;
      r_ws2 <= 1'b0;
    end else begin
      r_ws1 <= r_psel1 & r_penable & ~r_ws1;
      r_ws2 <= r_psel2 & r_penable & ~r_ws2;
    end
  end

  assign w_pready1 = r_ws1;
  assign w_pready2 = r_ws2;
`else
  assign w_pready1 = 1'b1;
  assign w_pready2 = 1'b1;
`endif

  assign w_pready   = r_psel2 ? w_pready2 : w_pready1;
  assign w_complete = r_penable & w_pready;
  assign w_slverr   = r_psel2 & r_paddr[7];
  assign w_prdata   = r_psel2 ? r_mem2[r_paddr[6:0]] : r_mem1[r_paddr];

  // Slave1 storage: full 256-byte map, written on write completion.
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      for (int i = 0; i < 256; i++) r_mem1[i] <= 8'h00;
    end else if (w_complete && r_psel1 && r_pwrite) begin
      r_mem1[r_paddr] <= r_pwdata;
    end
  end

  // Slave2 storage: only the lower 128 offsets exist; upper writes are dropped.
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      for (int i = 0; i < 128; i++) r_mem2[i] <= 8'h00;
    end else if (w_complete && r_psel2 && r_pwrite && !r_paddr[7]) begin
      r_mem2[r_paddr[6:0]] <= r_pwdata;
    end
  end

  // Capture read data on good read completion; pulse the error flag one cycle.
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      r_rdata   <= 8'h00;
      r_pslverr <= 1'b0;
    end else begin
      r_pslverr <= w_complete & w_slverr;
      if (w_complete && !r_pwrite && !w_slverr) begin
        r_rdata <= w_prdata;
      end
    end
  end

  assign apb_read_data_out = r_rdata;
  assign PSLVERR           = r_pslverr;

endmodule

// File: tb/tb_apb_bridge_top.sv
// Testbench for apb_bridge_top: directed scenarios plus random traffic,
// checked every cycle against a transaction-level reference model.
module tb_apb_bridge_top;

`ifdef WAIT_STATE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       transfer;
  logic       READ_WRITE;
  logic [8:0] apb_write_paddr;
  logic [7:0] apb_write_data;
  logic [8:0] apb_read_paddr;
  logic [7:0] apb_read_data_out;
  logic       PSLVERR;

  apb_bridge_top dut (
    .PCLK              (PCLK),
    .PRESETn           (PRESETn),
    .transfer          (transfer),
    .READ_WRITE        (READ_WRITE),
    .apb_write_paddr   (apb_write_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_paddr    (apb_read_paddr),
    .apb_read_data_out (apb_read_data_out),
    .PSLVERR           (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h required=%02h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [7:0] m_mem1 [256];
  logic [7:0] m_mem2 [128];
  logic [7:0] exp_rdata;
  logic       exp_err;
  bit         started = 0;
  bit         busy;
  bit         p_read;
  logic [8:0] p_addr;
  logic [7:0] p_data;
  int         cyc = 0;
  int         done_cyc;
  int         n_done = 0;

  // A request accepted at edge E completes at edge E+LAT; a new request is
  // accepted whenever the bridge is free (or just freed) and transfer is high.
  always @(posedge PCLK) begin
    if (PRESETn) begin
      for (int i = 0; i < 256; i++) m_mem1[i] = 8'h00;
      for (int i = 0; i < 128; i++) m_mem2[i] = 8'h00;
      exp_rdata = 8'h00;
      exp_err   = 1'b0;
      busy      = 0;
      started   = 1;
    end else begin
      exp_err = 1'b0;
      if (busy && cyc == done_cyc) begin
        busy = 0;
        n_done++;
        if (p_addr[8] && p_addr >= 9'h180) exp_err = 1'b1;
        else if (p_read) exp_rdata = p_addr[8] ? m_mem2[p_addr - 9'h100] : m_mem1[p_addr[7:0]];
        else if (p_addr[8]) m_mem2[p_addr - 9'h100] = p_data;
        else m_mem1[p_addr[7:0]] = p_data;
      end
      if (!busy && transfer) begin
        busy     = 1;
        done_cyc = cyc + LAT;
        p_read   = READ_WRITE;
        p_addr   = READ_WRITE ? apb_read_paddr : apb_write_paddr;
        p_data   = apb_write_data;
      end
    end
    cyc++;
  end

  // Every-cycle comparison of the DUT outputs against the model.
  always @(negedge PCLK) begin
    if (started) begin
      chk("cyc_rdata", apb_read_data_out, exp_rdata);
      chk("cyc_pslverr", {7'b0, PSLVERR}, {7'b0, exp_err});
    end
  end

  // ---------------- stimulus ----------------
  task automatic txn(input bit rd, input logic [8:0] addr, input logic [7:0] data);
    @(negedge PCLK);
    transfer   = 1'b1;
    READ_WRITE = rd;
    if (rd) apb_read_paddr = addr;
    else begin
      apb_write_paddr = addr;
      apb_write_data  = data;
    end
    @(negedge PCLK);
    transfer = 1'b0;
    repeat (LAT) @(negedge PCLK);
    $display("txn %s addr=%03h wdata=%02h rdata=%02h err=%0b",
             rd ? "RD" : "WR", addr, data, apb_read_data_out, PSLVERR);
  endtask

  task automatic set_req(input bit rd, input logic [8:0] addr, input logic [7:0] data);
    transfer   = 1'b1;
    READ_WRITE = rd;
    if (rd) apb_read_paddr = addr;
    else begin
      apb_write_paddr = addr;
      apb_write_data  = data;
    end
  endtask

  function automatic logic [8:0] rnd_addr();
    logic [7:0] off;
    logic       hi;
    hi = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0) off = 8'($urandom_range(128, 255));
    else off = 8'($urandom_range(0, 7));
    return {hi, off};
  endfunction

  int n0;

  initial begin
    PRESETn         = 1'b1;
    transfer        = 1'b0;
    READ_WRITE      = 1'b0;
    apb_write_paddr = 9'h000;
    apb_write_data  = 8'h00;
    apb_read_paddr  = 9'h000;

    // Reset
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b0;
    chk("reset_rdata", apb_read_data_out, 8'h00);
    chk("reset_pslverr", {7'b0, PSLVERR}, 8'h00);

    // Write then read back
    txn(0, 9'h010, 8'hA5);
    txn(1, 9'h010, 8'h00);
    chk("raw_rdata", apb_read_data_out, 8'hA5);
    chk("raw_model", exp_rdata, 8'hA5);
    chk("raw_pslverr", {7'b0, PSLVERR}, 8'h00);

    // Slave separation
    txn(0, 9'h105, 8'h3C);
    txn(1, 9'h105, 8'h00);
    chk("s2_rdata", apb_read_data_out, 8'h3C);
    txn(1, 9'h005, 8'h00);
    chk("s1_sep_rdata", apb_read_data_out, 8'h00);

    // Unmapped slave2 range
    txn(1, 9'h010, 8'h00);
    txn(1, 9'h1F0, 8'h00);
    chk("unmap_rd_err", {7'b0, PSLVERR}, 8'h01);
    chk("unmap_rd_keep", apb_read_data_out, 8'hA5);
    @(negedge PCLK);
    chk("unmap_err_pulse", {7'b0, PSLVERR}, 8'h00);
    txn(0, 9'h1F0, 8'h77);
    chk("unmap_wr_err", {7'b0, PSLVERR}, 8'h01);
    txn(1, 9'h170, 8'h00);
    chk("unmap_wr_drop", apb_read_data_out, 8'h00);

    // Back-to-back with transfer held high
    n0 = n_done;
    @(negedge PCLK);
    set_req(0, 9'h030, 8'h11);
    @(negedge PCLK);
    set_req(1, 9'h030, 8'h00);
    repeat (LAT) @(negedge PCLK);
    set_req(0, 9'h131, 8'h22);
    repeat (LAT) @(negedge PCLK);
    set_req(1, 9'h131, 8'h00);
    repeat (LAT) @(negedge PCLK);
    transfer = 1'b0;
    repeat (LAT) @(negedge PCLK);
    $display("txn B2B four transfers rdata=%02h", apb_read_data_out);
    chk("b2b_rdata", apb_read_data_out, 8'h22);
    chk("b2b_count", 8'(n_done - n0), 8'd4);

    // Reset during ACCESS of a write
    @(negedge PCLK);
    set_req(0, 9'h020, 8'h55);
    @(negedge PCLK);
    transfer = 1'b0;
    @(negedge PCLK);
    #1 PRESETn = 1'b1;
    @(negedge PCLK);
    #1 PRESETn = 1'b0;
    txn(1, 9'h020, 8'h00);
    chk("rst_abort_rdata", apb_read_data_out, 8'h00);

    // Random traffic, including occasional resets
    for (int k = 0; k < 600; k++) begin
      @(negedge PCLK);
      transfer        = ($urandom_range(0, 9) < 7);
      READ_WRITE      = 1'($urandom_range(0, 1));
      apb_write_paddr = rnd_addr();
      apb_read_paddr  = rnd_addr();
      apb_write_data  = 8'($urandom);
      #1 PRESETn = ($urandom_range(0, 149) == 0);
    end
    @(negedge PCLK);
    transfer = 1'b0;
    #1 PRESETn = 1'b0;
    repeat (LAT + 3) @(negedge PCLK);
    $display("txn RANDOM completed=%0d", n_done);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
